// File: rtl/dmem_mmio_pkg.sv
// Shared constants for the data memory / MMIO block: register offsets inside
// the 256-byte window and the TCTRL bit layout.
package dmem_mmio_pkg;

    localparam logic [7:0] OFF_LED    = 8'h00;
    localparam logic [7:0] OFF_SW     = 8'h04;
    localparam logic [7:0] OFF_TCTRL  = 8'h08;
    localparam logic [7:0] OFF_TLOAD  = 8'h0C;
    localparam logic [7:0] OFF_TCOUNT = 8'h10;
    localparam logic [7:0] OFF_CYCLE  = 8'h14;

    localparam int TC_EN   = 0;
    localparam int TC_AUTO = 1;
    localparam int TC_DONE = 2;

    typedef struct packed {
        logic done;
        logic auto_rl;
        logic en;
    } tctrl_t;

    // Places the control flags at their architectural bit positions.
    function automatic logic [31:0] tctrl_word(input tctrl_t t);
        logic [31:0] w;
        w          = '0;
        w[TC_EN]   = t.en;
        w[TC_AUTO] = t.auto_rl;
        w[TC_DONE] = t.done;
        return w;
    endfunction

endpackage

// File: rtl/mmio_timer.sv
// Down-timer behind the TCTRL/TLOAD/TCOUNT registers. A TLOAD write beats the
// countdown; a DONE set beats a same-cycle write-1-to-clear.
module mmio_timer
    import dmem_mmio_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        tctrl_we_i,
    input  logic        tload_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] tcount_o,
    output logic [31:0] tload_o,
    output tctrl_t      tctrl_o,
    output logic        done_o
);

    logic [31:0] tcount_q, tcount_d;
    logic [31:0] tload_q, tload_d;
    tctrl_t      tctrl_q, tctrl_d;
    logic        done_set;

    always_comb begin
        tcount_d = tcount_q;
        tload_d  = tload_q;
        tctrl_d  = tctrl_q;
        done_set = 1'b0;

        if (tload_we_i) begin
            tload_d  = wdata_i;
            tcount_d = wdata_i;
        end else if (tctrl_q.en && tcount_q == 32'd1) begin
            tcount_d = tctrl_q.auto_rl ? tload_q : '0;
            done_set = 1'b1;
        end else if (tctrl_q.en && tcount_q > 32'd1) begin
            tcount_d = tcount_q - 32'd1;
        end

        if (tctrl_we_i) begin
            tctrl_d.en      = wdata_i[TC_EN];
            tctrl_d.auto_rl = wdata_i[TC_AUTO];
            if (wdata_i[TC_DONE]) begin
                tctrl_d.done = 1'b0;
            end
        end

        if (done_set) begin
            tctrl_d.done = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tcount_q <= '0;
            tload_q  <= '0;
            tctrl_q  <= '0;
        end else begin
            tcount_q <= tcount_d;
            tload_q  <= tload_d;
            tctrl_q  <= tctrl_d;
        end
    end

    assign tcount_o = tcount_q;
    assign tload_o  = tload_q;
    assign tctrl_o  = tctrl_q;
    assign done_o   = tctrl_q.done;

endmodule

// File: rtl/dmem_mmio.sv
// Data-side memory for the single-cycle core: word RAM plus a small MMIO window
// (LED, switches, timer, cycle counter). Reads are combinational.
module dmem_mmio
    import dmem_mmio_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'h0000_7F00,
    parameter int          SW_W        = 16,
    parameter int          LED_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      addr,
    input  logic             MemWrite,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [SW_W-1:0]  sw,
    output logic [LED_W-1:0] led,
    output logic             timer_irq
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic             mmio;
    logic [7:0]       off;
    logic [AW-1:0]    ram_idx;
    logic             wr_mmio, led_we, tctrl_we, tload_we;
    logic             unused_byte_sel;

    logic [31:0]      ram_q [DEPTH_WORDS];
    logic [LED_W-1:0] led_q;
    logic [SW_W-1:0]  sw_meta_q, sw_sync_q;
    logic [31:0]      cycle_q;
    logic [31:0]      mmio_rdata;

    logic [31:0]      tcount, tload;
    tctrl_t           tctrl;
    logic             done;

    // Word-only accesses: the byte lane bits never take part in decode.
    assign mmio            = (addr[31:8] == MMIO_BASE[31:8]);
    assign off             = {addr[7:2], 2'b00};
    assign ram_idx         = addr[AW+1:2];
    assign unused_byte_sel = ^addr[1:0];

    assign wr_mmio  = MemWrite && mmio;
    assign led_we   = wr_mmio && (off == OFF_LED);
    assign tctrl_we = wr_mmio && (off == OFF_TCTRL);
    assign tload_we = wr_mmio && (off == OFF_TLOAD);

    always_ff @(posedge clk) begin
        if (MemWrite && !mmio) begin
            ram_q[ram_idx] <= writedata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q     <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            cycle_q   <= '0;
        end else begin
            if (led_we) begin
                led_q <= writedata[LED_W-1:0];
            end
            sw_meta_q <= sw;
            sw_sync_q <= sw_meta_q;
            cycle_q   <= cycle_q + 32'd1;
        end
    end

    mmio_timer u_timer (
        .clk_i      (clk),
        .rst_i      (rst),
        .tctrl_we_i (tctrl_we),
        .tload_we_i (tload_we),
        .wdata_i    (writedata),
        .tcount_o   (tcount),
        .tload_o    (tload),
        .tctrl_o    (tctrl),
        .done_o     (done)
    );

    always_comb begin
        mmio_rdata = '0;
        case (off)
            OFF_LED:    mmio_rdata[LED_W-1:0] = led_q;
            OFF_SW:     mmio_rdata[SW_W-1:0]  = sw_sync_q;
            OFF_TCTRL:  mmio_rdata            = tctrl_word(tctrl);
            OFF_TLOAD:  mmio_rdata            = tload;
            OFF_TCOUNT: mmio_rdata            = tcount;
            OFF_CYCLE:  mmio_rdata            = cycle_q;
            default:    mmio_rdata            = '0;
        endcase
    end

    assign readdata  = mmio ? mmio_rdata : ram_q[ram_idx];
    assign led       = led_q;
    assign timer_irq = done;

endmodule

// File: tb/tb_dmem_mmio.sv
// Bench for dmem_mmio: directed vector table, hand-written multi-cycle
// sequences, and randomized traffic checked against a behavioural model.
module tb_dmem_mmio;

    localparam logic [31:0] B     = 32'h0000_7F00;
    localparam int          DEPTH = 1024;

    typedef struct {
        logic [31:0] a;
        logic        we;
        logic [31:0] wd;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        chk_irq;
        logic        exp_irq;
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic        MemWrite = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [15:0] sw = '0;
    logic [15:0] led;
    logic        timer_irq;

    int total = 0;
    int bad   = 0;
    int edge_cnt = 0;
    int rst_edge = 0;

    vec_t        vq[$];
    logic [31:0] ram_m [int];
    int          widx[$];
    logic [15:0] led_m;

    dmem_mmio dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .MemWrite  (MemWrite),
        .writedata (writedata),
        .readdata  (readdata),
        .sw        (sw),
        .led       (led),
        .timer_irq (timer_irq)
    );

    always #10 clk = ~clk;

    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        if (rst) rst_edge <= edge_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] cyc_exp();
        return 32'(edge_cnt - rst_edge);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] a, input logic we, input logic [31:0] wd,
                                input logic cr, input logic [31:0] er,
                                input logic ci, input logic ei, input string nm);
        vec_t v;
        v.a = a; v.we = we; v.wd = wd;
        v.chk_rd = cr; v.exp_rd = er;
        v.chk_irq = ci; v.exp_irq = ei;
        v.name = nm;
        return v;
    endfunction

    function automatic void vw(input logic [31:0] a, input logic [31:0] wd, input string nm);
        vq.push_back(mk(a, 1'b1, wd, 1'b0, '0, 1'b0, 1'b0, nm));
    endfunction

    function automatic void vr(input logic [31:0] a, input logic [31:0] e, input string nm);
        vq.push_back(mk(a, 1'b0, '0, 1'b1, e, 1'b0, 1'b0, nm));
    endfunction

    function automatic void vri(input logic [31:0] a, input logic [31:0] e, input logic irq, input string nm);
        vq.push_back(mk(a, 1'b0, '0, 1'b1, e, 1'b1, irq, nm));
    endfunction

    function automatic void vwc(input logic [31:0] a, input logic [31:0] wd, input logic [31:0] old,
                                input logic irq, input string nm);
        vq.push_back(mk(a, 1'b1, wd, 1'b1, old, 1'b1, irq, nm));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v);
        addr = v.a; MemWrite = v.we; writedata = v.wd;
        #2;
        if (v.chk_rd)  check(v.name, readdata, v.exp_rd);
        if (v.chk_irq) check({v.name, "_irq"}, 32'(timer_irq), 32'(v.exp_irq));
        tick();
        MemWrite = 1'b0;
    endtask

    task automatic peek(input logic [31:0] a, input logic [31:0] exp, input string nm);
        addr = a; MemWrite = 1'b0;
        #1;
        check(nm, readdata, exp);
    endtask

    function automatic logic [31:0] ram_addr(input int idx);
        logic [31:0] a;
        a = 32'(idx) * 32'd4 + 32'($urandom_range(0, 3)) + ($urandom() << 12);
        if ((a >> 8) == (B >> 8)) a = a ^ 32'h0010_0000;
        return a;
    endfunction

    initial begin
        int          k, op, j;
        logic [31:0] a, d;
        logic [15:0] s;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        peek(B + 32'h00, 32'h0, "rst_led");
        peek(B + 32'h04, 32'h0, "rst_sw");
        peek(B + 32'h08, 32'h0, "rst_tctrl");
        peek(B + 32'h0C, 32'h0, "rst_tload");
        peek(B + 32'h10, 32'h0, "rst_tcount");
        peek(B + 32'h14, 32'h0, "rst_cycle");
        check("rst_led_port", 32'(led), 32'h0);
        check("rst_irq", 32'(timer_irq), 32'h0);
        tick();

        // RAM store/load, aliasing, read-old-on-write
        vw(32'h10, 32'hDEADBEEF, "st10");
        vw(32'h14, 32'hCAFEF00D, "st14");
        vr(32'h10, 32'hDEADBEEF, "ld10");
        vr(32'h14, 32'hCAFEF00D, "ld14");
        vr(32'h13, 32'hDEADBEEF, "ld13");
        vr(32'h1010, 32'hDEADBEEF, "ld_alias");
        vq.push_back(mk(32'h10, 1'b1, 32'h01234567, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, "st_rd_old"));
        vr(32'h10, 32'h01234567, "ld10_new");
        // LED
        vw(B + 32'h00, 32'h0001A5A5, "led_wr");
        vr(B + 32'h00, 32'h0000A5A5, "led_rd");
        // One-shot timer
        vw(B + 32'h08, 32'h1, "os_tctrl");
        vw(B + 32'h0C, 32'h3, "os_tload");
        vri(B + 32'h10, 32'd3, 1'b0, "os_c3");
        vri(B + 32'h10, 32'd2, 1'b0, "os_c2");
        vri(B + 32'h10, 32'd1, 1'b0, "os_c1");
        vri(B + 32'h10, 32'd0, 1'b1, "os_c0");
        vri(B + 32'h08, 32'h5, 1'b1, "os_tctrl_done");
        vri(B + 32'h10, 32'd0, 1'b1, "os_hold");
        vwc(B + 32'h08, 32'h5, 32'h5, 1'b1, "os_w1c");
        vri(B + 32'h08, 32'h1, 1'b0, "os_cleared");
        // Auto-reload, W1C vs coincident set
        vwc(B + 32'h08, 32'h3, 32'h1, 1'b0, "ar_tctrl");
        vw(B + 32'h0C, 32'h2, "ar_tload");
        vri(B + 32'h10, 32'd2, 1'b0, "ar_a");
        vri(B + 32'h10, 32'd1, 1'b0, "ar_b");
        vri(B + 32'h10, 32'd2, 1'b1, "ar_c");
        vri(B + 32'h10, 32'd1, 1'b1, "ar_d");
        vri(B + 32'h10, 32'd2, 1'b1, "ar_e");
        vwc(B + 32'h08, 32'h7, 32'h7, 1'b1, "ar_w1c_coinc");
        vri(B + 32'h08, 32'h7, 1'b1, "ar_set_wins");
        vri(B + 32'h10, 32'd1, 1'b1, "ar_f");
        vwc(B + 32'h08, 32'h7, 32'h7, 1'b1, "ar_w1c");
        vri(B + 32'h08, 32'h3, 1'b0, "ar_cleared");
        vri(B + 32'h08, 32'h7, 1'b1, "ar_reset_again");
        vwc(B + 32'h08, 32'h4, 32'h7, 1'b1, "ar_stop");
        vri(B + 32'h08, 32'h4, 1'b1, "ar_stopped");
        vri(B + 32'h10, 32'd2, 1'b1, "ar_held");
        vwc(B + 32'h08, 32'h4, 32'h4, 1'b1, "ar_clr");
        vri(B + 32'h08, 32'h0, 1'b0, "ar_idle");
        vr(B + 32'h0C, 32'h2, "tload_rd");
        // Unmapped and read-only writes must not reach RAM or registers
        vw(32'h0F18, 32'h11112222, "alias18_st");
        vw(32'h0F10, 32'h33334444, "alias10_st");
        vw(B + 32'h18, 32'hFFFFFFFF, "unmap_wr");
        vw(B + 32'h10, 32'hFFFFFFFF, "ro_wr");
        vr(B + 32'h18, 32'h0, "unmap_rd");
        vr(B + 32'h10, 32'd2, "ro_tcount");
        vr(32'h0F18, 32'h11112222, "alias18_ld");
        vr(32'h0F10, 32'h33334444, "alias10_ld");

        foreach (vq[i]) apply(vq[i]);
        check("led_port", 32'(led), 32'h0000A5A5);

        // Switch synchronizer: two-edge latency
        sw = 16'h1234;
        peek(B + 32'h04, 32'h0, "sw_c0");
        tick();
        peek(B + 32'h04, 32'h0, "sw_c1");
        tick();
        peek(B + 32'h04, 32'h1234, "sw_c2");
        tick();

        // Random one-shot durations: TCOUNT = K-j+1 in cycle N+j, DONE from N+K+1
        for (int t = 0; t < 6; t++) begin
            k = int'($urandom_range(1, 8));
            apply(mk(B + 32'h08, 1'b1, 32'h1, 1'b0, '0, 1'b0, 1'b0, "rt_en"));
            apply(mk(B + 32'h0C, 1'b1, 32'(k), 1'b0, '0, 1'b0, 1'b0, "rt_load"));
            for (int n = 1; n <= k + 2; n++) begin
                peek(B + 32'h10, (n <= k) ? 32'(k - n + 1) : 32'h0, "rt_tcount");
                check("rt_irq", 32'(timer_irq), (n >= k + 1) ? 32'h1 : 32'h0);
                tick();
            end
            apply(mk(B + 32'h08, 1'b1, 32'h4, 1'b0, '0, 1'b0, 1'b0, "rt_clr"));
        end

        // Reset mid-operation
        apply(mk(B + 32'h08, 1'b1, 32'h1, 1'b0, '0, 1'b0, 1'b0, "mr_en"));
        apply(mk(B + 32'h0C, 1'b1, 32'h1, 1'b0, '0, 1'b0, 1'b0, "mr_t1"));
        apply(mk(B + 32'h00, 1'b1, 32'hFF, 1'b0, '0, 1'b0, 1'b0, "mr_led"));
        apply(mk(B + 32'h0C, 1'b1, 32'd50, 1'b0, '0, 1'b0, 1'b0, "mr_t50"));
        peek(B + 32'h10, 32'd50, "mr_tcount50");
        check("mr_irq_pre", 32'(timer_irq), 32'h1);
        peek(B + 32'h14, cyc_exp(), "mr_cycle_pre");
        tick();
        peek(B + 32'h10, 32'd49, "mr_tcount49");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        peek(B + 32'h00, 32'h0, "mr_led");
        peek(B + 32'h04, 32'h0, "mr_sw");
        peek(B + 32'h08, 32'h0, "mr_tctrl");
        peek(B + 32'h0C, 32'h0, "mr_tload");
        peek(B + 32'h10, 32'h0, "mr_tcount");
        peek(B + 32'h14, 32'h0, "mr_cycle");
        peek(32'h10, 32'h01234567, "mr_ram10");
        peek(32'h14, 32'hCAFEF00D, "mr_ram14");
        check("mr_led_port", 32'(led), 32'h0);
        check("mr_irq", 32'(timer_irq), 32'h0);
        tick();
        peek(B + 32'h14, 32'd1, "mr_cycle1");
        tick();
        peek(B + 32'h14, 32'd2, "mr_cycle2");
        tick();

        // Randomized traffic against the behavioural model
        led_m = '0;
        for (int n = 0; n < 300; n++) begin
            op = int'($urandom_range(0, 6));
            if (op == 1 && widx.size() == 0) op = 0;
            case (op)
                0: begin
                    a = ram_addr(int'($urandom_range(0, DEPTH - 1)));
                    d = $urandom();
                    j = int'((a >> 2) % DEPTH);
                    ram_m[j] = d;
                    widx.push_back(j);
                    apply(mk(a, 1'b1, d, 1'b0, '0, 1'b0, 1'b0, "rnd_st"));
                end
                1: begin
                    j = widx[$urandom_range(0, widx.size() - 1)];
                    apply(mk(ram_addr(j), 1'b0, '0, 1'b1, ram_m[j], 1'b0, 1'b0, "rnd_ld"));
                end
                2: begin
                    d = $urandom();
                    led_m = d[15:0];
                    apply(mk(B, 1'b1, d, 1'b0, '0, 1'b0, 1'b0, "rnd_led_wr"));
                end
                3: begin
                    check("rnd_led_port", 32'(led), 32'(led_m));
                    apply(mk(B, 1'b0, '0, 1'b1, 32'(led_m), 1'b0, 1'b0, "rnd_led_rd"));
                end
                4: begin
                    a = B + 32'($urandom_range(6, 63)) * 32'd4 + 32'($urandom_range(0, 3));
                    apply(mk(a, 1'b1, $urandom(), 1'b1, 32'h0, 1'b0, 1'b0, "rnd_unmap"));
                end
                5: begin
                    peek(B + 32'h14, cyc_exp(), "rnd_cycle");
                    tick();
                end
                default: begin
                    s = 16'($urandom());
                    sw = s;
                    tick();
                    tick();
                    peek(B + 32'h04, 32'(s), "rnd_sw");
                    tick();
                end
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
